// File: rtl/alu_sequencer_if.sv
// Bundle between the instruction decoder / ALU datapath and alu_sequencer.
// The master side offers commands and returns ALU results; the slave side is the sequencer.
interface alu_sequencer_if;
    // Command handshake: a command transfers on a rising clk edge where
    // cmd_valid && cmd_ready. cmd_ready is high only while the sequencer is idle.
    // The master holds cmd_valid and every cmd_* field stable until that transfer.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [2:0] cmd_src1;
    logic [2:0] cmd_src2;
    logic [7:0] cmd_alu_op;
    logic       cmd_cin;
    logic [1:0] cmd_dst;
    logic       cmd_set_c;

    logic [2:0] input_1_select;
    logic [2:0] input_2_select;
    logic [7:0] alu_opcode;
    logic       cin;
    logic [7:0] alu_out;
    logic       alu_cout;

    logic       wr_en;
    logic [1:0] wr_dst;
    logic [7:0] wr_data;
    logic       flag_we;
    logic       flag_c_we;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;

    logic       addr_valid;
    logic [7:0] addr_lo;
    logic [7:0] addr_hi;
    logic       page_cross;

    modport master (
        output cmd_valid, cmd_type, cmd_src1, cmd_src2, cmd_alu_op, cmd_cin,
               cmd_dst, cmd_set_c, alu_out, alu_cout,
        input  cmd_ready, input_1_select, input_2_select, alu_opcode, cin,
               wr_en, wr_dst, wr_data, flag_we, flag_c_we, flag_n, flag_z,
               flag_c, addr_valid, addr_lo, addr_hi, page_cross
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_src1, cmd_src2, cmd_alu_op, cmd_cin,
               cmd_dst, cmd_set_c, alu_out, alu_cout,
        output cmd_ready, input_1_select, input_2_select, alu_opcode, cin,
               wr_en, wr_dst, wr_data, flag_we, flag_c_we, flag_n, flag_z,
               flag_c, addr_valid, addr_lo, addr_hi, page_cross
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared ALU datapath: ALU op / compare with
// write-back and flags, plus the two-cycle indexed-address add.
module alu_sequencer #(
    parameter logic [7:0] OP_ADD  = 8'h00,
    parameter logic [7:0] OP_PASS = 8'h0F,
    parameter logic [7:0] OP_INC  = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_sequencer_if.slave        bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        ADDR_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] T_ALU  = 2'd0;
    localparam logic [1:0] T_ADDR = 2'd2;
    localparam logic [1:0] T_RSVD = 2'd3;
    localparam logic [2:0] SEL_A       = 3'd0;
    localparam logic [2:0] SEL_DATA_IN = 3'd3;

    state_t     state, next_state;
    logic       accept;

    logic [1:0] type_q;
    logic [2:0] src1_q, src2_q;
    logic [7:0] op_q;
    logic       cin_q;
    logic [1:0] dst_q;
    logic       set_c_q;

    logic [7:0] res_q;
    logic       c_q;

    logic [1:0] wr_dst_q;
    logic [7:0] wr_data_q;
    logic       flag_n_q, flag_z_q, flag_c_q;
    logic [7:0] addr_lo_q, addr_hi_q;
    logic       page_cross_q;

    assign accept    = bus.cmd_valid && (state == IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && bus.cmd_type != T_RSVD) next_state = EXEC;
            EXEC:    next_state = (type_q == T_ADDR) ? ADDR_HI : DONE;
            ADDR_HI: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.input_1_select = SEL_A;
        bus.input_2_select = SEL_A;
        bus.alu_opcode     = OP_PASS;
        bus.cin            = 1'b0;
        bus.wr_en          = 1'b0;
        bus.flag_we        = 1'b0;
        bus.flag_c_we      = 1'b0;
        bus.addr_valid     = 1'b0;
        case (state)
            IDLE: bus.cmd_ready = 1'b1;
            EXEC: begin
                bus.input_1_select = src1_q;
                bus.input_2_select = src2_q;
                if (type_q == T_ADDR) begin
                    bus.alu_opcode = OP_ADD;
                end else begin
                    bus.alu_opcode = op_q;
                    bus.cin        = cin_q;
                end
            end
            ADDR_HI: begin
                // DATA_IN carries the base high byte; bump it only when the low add carried.
                bus.input_1_select = SEL_DATA_IN;
                bus.alu_opcode     = c_q ? OP_INC : OP_PASS;
            end
            DONE: begin
                bus.wr_en      = (type_q == T_ALU);
                bus.flag_we    = (type_q != T_ADDR);
                bus.flag_c_we  = (type_q != T_ADDR) && set_c_q;
                bus.addr_valid = (type_q == T_ADDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            type_q  <= 2'd0;
            src1_q  <= 3'd0;
            src2_q  <= 3'd0;
            op_q    <= 8'd0;
            cin_q   <= 1'b0;
            dst_q   <= 2'd0;
            set_c_q <= 1'b0;
        end else if (accept) begin
            type_q  <= bus.cmd_type;
            src1_q  <= bus.cmd_src1;
            src2_q  <= bus.cmd_src2;
            op_q    <= bus.cmd_alu_op;
            cin_q   <= bus.cmd_cin;
            dst_q   <= bus.cmd_dst;
            set_c_q <= bus.cmd_set_c;
        end
    end

    // Visible outputs load on the edge into DONE so they first change in DONE and then hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q        <= 8'd0;
            c_q          <= 1'b0;
            wr_dst_q     <= 2'd0;
            wr_data_q    <= 8'd0;
            flag_n_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            addr_lo_q    <= 8'd0;
            addr_hi_q    <= 8'd0;
            page_cross_q <= 1'b0;
        end else begin
            if (state == EXEC) begin
                res_q <= bus.alu_out;
                c_q   <= bus.alu_cout;
                if (type_q != T_ADDR) begin
                    flag_n_q <= bus.alu_out[7];
                    flag_z_q <= (bus.alu_out == 8'd0);
                    flag_c_q <= bus.alu_cout;
                end
                if (type_q == T_ALU) begin
                    wr_dst_q  <= dst_q;
                    wr_data_q <= bus.alu_out;
                end
            end
            if (state == ADDR_HI) begin
                addr_lo_q    <= res_q;
                addr_hi_q    <= bus.alu_out;
                page_cross_q <= c_q;
            end
        end
    end

    assign bus.wr_dst     = wr_dst_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.flag_n     = flag_n_q;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_c     = flag_c_q;
    assign bus.addr_lo    = addr_lo_q;
    assign bus.addr_hi    = addr_hi_q;
    assign bus.page_cross = page_cross_q;

endmodule
